// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage IEEE 754 adder/subtractor with a valid/ready stream interface.
// Generic exponent/fraction widths (half, single, double). Round-to-nearest-even,
// subnormal support and {invalid, overflow, underflow, inexact} flags.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   in_valid / in_ready - operand beat handshake (a, b, op: 0 = a+b, 1 = a-b)
//   out_valid/out_ready - result beat handshake (result, flags)
//
// Stages: S1 unpack/classify/swap/align, S2 significand add, S3 normalise/round/pack.
// The whole pipe holds while the output beat is stalled.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int unsigned W  = EXP_W + MAN_W + 1;
    localparam int unsigned SW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
    localparam int unsigned AW = MAN_W + 5;  // adder width incl. carry
    localparam int unsigned XW = EXP_W + 1;  // internal exponent with headroom
    localparam logic [EXP_W-1:0] ColLim = EXP_W'(MAN_W + 3);

    logic stall;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // ---------------------------------------------------------------- S1
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             a_ge;
    logic             sl, ss;
    logic [EXP_W-1:0] el, es, diff;
    logic [MAN_W:0]   sigl, sigs;
    logic [2*SW-1:0]  wide;
    logic [SW-1:0]    small_al;
    logic             spec;
    logic [W-1:0]     spec_res, qnan;
    logic [3:0]       spec_flags;

    always_comb begin
        sa = a[W-1];
        sb = b[W-1] ^ op;
        ea = a[W-2:MAN_W];
        eb = b[W-2:MAN_W];
        ma = a[MAN_W-1:0];
        mb = b[MAN_W-1:0];

        a_zero = (ea == '0) && (ma == '0);
        b_zero = (eb == '0) && (mb == '0);
        a_inf  = (&ea) && (ma == '0);
        b_inf  = (&eb) && (mb == '0);
        a_nan  = (&ea) && (ma != '0);
        b_nan  = (&eb) && (mb != '0);
        a_snan = a_nan && !ma[MAN_W-1];
        b_snan = b_nan && !mb[MAN_W-1];

        // Subnormals behave as exponent 1 with a clear hidden bit.
        ea_eff = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff = (eb == '0) ? EXP_W'(1) : eb;

        // Raw {exp, frac} ordering equals magnitude ordering.
        a_ge = {ea, ma} >= {eb, mb};
        sl   = a_ge ? sa : sb;
        ss   = a_ge ? sb : sa;
        el   = a_ge ? ea_eff : eb_eff;
        es   = a_ge ? eb_eff : ea_eff;
        sigl = a_ge ? {ea != '0, ma} : {eb != '0, mb};
        sigs = a_ge ? {eb != '0, mb} : {ea != '0, ma};
        diff = el - es;

        // Low half of the wide shift catches everything shifted past sticky.
        wide = {sigs, 3'b000, {SW{1'b0}}} >> diff;
        if (diff >= ColLim) begin
            small_al = {{(SW-1){1'b0}}, |sigs};
        end else begin
            small_al = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
        end

        qnan       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        spec       = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res   = qnan;
            spec_flags = {a_snan | b_snan, 3'b000};
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_res   = qnan;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_res = {sa, a[W-2:0]};
        end else if (b_inf) begin
            spec_res = {sb, b[W-2:0]};
        end else if (a_zero && b_zero) begin
            spec_res = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_res = {sb, b[W-2:0]};
        end else if (b_zero) begin
            spec_res = a;
        end else begin
            spec = 1'b0;
        end
    end

    logic             v1_q, v1_d;
    logic             s1_spec_q, s1_spec_d;
    logic [W-1:0]     s1_sres_q, s1_sres_d;
    logic [3:0]       s1_sflg_q, s1_sflg_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_sub_q, s1_sub_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [SW-1:0]    s1_sigl_q, s1_sigl_d;
    logic [SW-1:0]    s1_sigs_q, s1_sigs_d;

    always_comb begin
        v1_d      = stall ? v1_q : in_valid;
        s1_spec_d = stall ? s1_spec_q : spec;
        s1_sres_d = stall ? s1_sres_q : spec_res;
        s1_sflg_d = stall ? s1_sflg_q : spec_flags;
        s1_sign_d = stall ? s1_sign_q : sl;
        s1_sub_d  = stall ? s1_sub_q  : (sl ^ ss);
        s1_exp_d  = stall ? s1_exp_q  : el;
        s1_sigl_d = stall ? s1_sigl_q : {sigl, 3'b000};
        s1_sigs_d = stall ? s1_sigs_q : small_al;
    end

    // ---------------------------------------------------------------- S2
    logic [AW-1:0]    sum;
    logic             v2_q, v2_d;
    logic             s2_spec_q, s2_spec_d;
    logic [W-1:0]     s2_sres_q, s2_sres_d;
    logic [3:0]       s2_sflg_q, s2_sflg_d;
    logic             s2_sign_q, s2_sign_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic [AW-1:0]    s2_sum_q, s2_sum_d;

    always_comb begin
        // |L| >= |S|, so the difference never goes negative.
        sum = s1_sub_q ? ({1'b0, s1_sigl_q} - {1'b0, s1_sigs_q})
                       : ({1'b0, s1_sigl_q} + {1'b0, s1_sigs_q});
        v2_d      = stall ? v2_q      : v1_q;
        s2_spec_d = stall ? s2_spec_q : s1_spec_q;
        s2_sres_d = stall ? s2_sres_q : s1_sres_q;
        s2_sflg_d = stall ? s2_sflg_q : s1_sflg_q;
        s2_sign_d = stall ? s2_sign_q : s1_sign_q;
        s2_exp_d  = stall ? s2_exp_q  : s1_exp_q;
        s2_sum_d  = stall ? s2_sum_q  : sum;
    end

    // ---------------------------------------------------------------- S3
    logic [SW-1:0]  nm, m;
    logic [XW-1:0]  lz, lim, sh, e, e_f;
    logic           g, r, st, hidden, rnd, hid_f, inx, unf, ovf;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] frac_f;
    logic [W-1:0]   res_new;
    logic [3:0]     flags_new;
    logic           v3_q, v3_d;
    logic [W-1:0]   res_q, res_d;
    logic [3:0]     flags_q, flags_d;

    always_comb begin
        nm  = s2_sum_q[SW-1:0];
        lz  = XW'(SW);
        for (int i = 0; i < int'(SW); i++) begin
            if (nm[i]) lz = XW'(int'(SW) - 1 - i);
        end
        lim = {1'b0, s2_exp_q} - XW'(1);
        sh  = (lz < lim) ? lz : lim;

        if (s2_sum_q[AW-1]) begin
            m = {s2_sum_q[AW-1:2], s2_sum_q[1] | s2_sum_q[0]};
            e = {1'b0, s2_exp_q} + XW'(1);
        end else begin
            // Shift limit keeps exponent >= 1; a clear hidden bit then means subnormal.
            m = nm << sh;
            e = {1'b0, s2_exp_q} - sh;
        end

        hidden = m[SW-1];
        g      = m[2];
        r      = m[1];
        st     = m[0];
        rnd    = g & (r | st | m[3]);
        mant   = {1'b0, m[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
        if (mant[MAN_W+1]) begin
            frac_f = mant[MAN_W:1];
            hid_f  = 1'b1;
            e_f    = e + XW'(1);
        end else begin
            frac_f = mant[MAN_W-1:0];
            hid_f  = mant[MAN_W];
            e_f    = e;
        end

        inx = g | r | st;
        unf = !hidden && inx;
        ovf = e_f >= {1'b0, {EXP_W{1'b1}}};

        if (ovf) begin
            res_new   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_new = 4'b0101;
        end else begin
            // Exact cancellation rounds to +0.
            res_new   = {s2_sign_q && (s2_sum_q != '0),
                         hid_f ? e_f[EXP_W-1:0] : {EXP_W{1'b0}}, frac_f};
            flags_new = {2'b00, unf, inx};
        end
        if (s2_spec_q) begin
            res_new   = s2_sres_q;
            flags_new = s2_sflg_q;
        end

        v3_d    = stall ? v3_q : v2_q;
        res_d   = (!stall && v2_q) ? res_new   : res_q;
        flags_d = (!stall && v2_q) ? flags_new : flags_q;
    end

    assign out_valid = v3_q;
    assign result    = res_q;
    assign flags     = flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_spec_q <= s1_spec_d;
        s1_sres_q <= s1_sres_d;
        s1_sflg_q <= s1_sflg_d;
        s1_sign_q <= s1_sign_d;
        s1_sub_q  <= s1_sub_d;
        s1_exp_q  <= s1_exp_d;
        s1_sigl_q <= s1_sigl_d;
        s1_sigs_q <= s1_sigs_d;
        s2_spec_q <= s2_spec_d;
        s2_sres_q <= s2_sres_d;
        s2_sflg_q <= s2_sflg_d;
        s2_sign_q <= s2_sign_d;
        s2_exp_q  <= s2_exp_d;
        s2_sum_q  <= s2_sum_d;
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision instance plus a half-precision instance.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    int checks = 0;
    int errors = 0;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One beat into an empty pipe; out_valid must appear exactly 3 cycles later.
    task automatic run_vec(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic top, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " ov c1"}, out_valid, 0);
        @(negedge clk);
        check({tag, " ov c2"}, out_valid, 0);
        @(negedge clk);
        check({tag, " ov c3"}, out_valid, 1);
        check({tag, " result"}, result, er);
        check({tag, " flags"}, flags, ef);
    endtask

    logic [31:0] fv [10];
    logic [31:0] one_f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, dcount;
        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        one_f = 32'h3F800000;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_op = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset flags", flags, 0);
        check("reset in_ready", in_ready, 1);
        rst = 1'b0;

        run_vec("3+4",        32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, 4'b0000);
        run_vec("3+-3",       32'h40400000, 32'hC0400000, 1'b0, 32'h00000000, 4'b0000);
        run_vec("-0-0",       32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
        run_vec("inf-inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        run_vec("3--inf",     32'h40400000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000);
        run_vec("snan",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_vec("tie",        32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_vec("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_vec("subnormal",  32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 4'b0000);

        // Backpressure: 8 beats (k+1)+1, out_ready low for cycles 4..9.
        @(negedge clk);
        idx = 0; dcount = 0;
        for (int c = 0; c < 40 && dcount < 8; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = !(c >= 4 && c <= 9);
            if (idx < 8) begin
                in_valid = 1'b1; a = fv[idx]; b = one_f; op = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c <= 16) begin
                check($sformatf("bp in_ready c%0d", c), in_ready, (c >= 4 && c <= 9) ? 0 : 1);
                check($sformatf("bp out_valid c%0d", c), out_valid, (c >= 3) ? 1 : 0);
            end
            if (out_valid) begin
                check($sformatf("bp result beat%0d", dcount), result, fv[dcount + 1]);
                if (out_ready) dcount++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp delivered", dcount, 8);
        check("bp accepted", idx, 8);

        // Reset with two beats in flight, plus a beat offered during reset.
        @(negedge clk);
        in_valid = 1'b1; a = fv[2]; b = one_f; op = 1'b0;
        @(negedge clk);
        a = fv[3];
        @(negedge clk);
        rst = 1'b1; a = fv[4];
        #1 check("rst in_ready during", in_ready, 1);
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 0);
        check("rst flags", flags, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1 check("rst in_ready after", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rst flush ov %0d", k), out_valid, 0);
        end

        // Half precision: 1.0 + 1.0 = 2.0.
        @(negedge clk);
        h_in_valid = 1'b1; h_a = 16'h3C00; h_b = 16'h3C00; h_op = 1'b0; h_out_ready = 1'b1;
        @(negedge clk);
        h_in_valid = 1'b0;
        check("half ov c1", h_out_valid, 0);
        @(negedge clk);
        check("half ov c2", h_out_valid, 0);
        @(negedge clk);
        check("half ov c3", h_out_valid, 1);
        check("half result", h_result, 16'h4000);
        check("half flags", h_flags, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
